// File: rtl/opll_write_scheduler.sv
// Two-requester write scheduler for an OPLL core: round-robin arbiter, small
// {reg,data} FIFO, and a CLK_EN-timed FSM that paces address/data writes.
module opll_write_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int WR_TICKS   = 4,
    parameter int ADDR_WAIT  = 72,
    parameter int DATA_WAIT  = 504
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              CLK_EN,
    input  logic                              CLR,
    input  logic                              REQ0_VALID,
    output logic                              REQ0_READY,
    input  logic [7:0]                        REQ0_REG,
    input  logic [7:0]                        REQ0_DATA,
    input  logic                              REQ1_VALID,
    output logic                              REQ1_READY,
    input  logic [7:0]                        REQ1_REG,
    input  logic [7:0]                        REQ1_DATA,
    output logic                              OPLL_CS_n,
    output logic                              OPLL_WR_n,
    output logic                              OPLL_A0,
    output logic [7:0]                        OPLL_D,
    output logic                              BUSY,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   LEVEL
);
    localparam int LW     = $clog2(FIFO_DEPTH + 1);
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int MAX_T1 = (WR_TICKS > ADDR_WAIT) ? WR_TICKS : ADDR_WAIT;
    localparam int MAX_T  = (MAX_T1 > DATA_WAIT) ? MAX_T1 : DATA_WAIT;
    localparam int CW     = $clog2(MAX_T + 1);
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, ADR_WR, ADR_WAIT, DAT_WR, DAT_WAIT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]   level_q, level_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic            rr_q, rr_d;
    logic            run_q;
    logic            cs_q, cs_d, wr_q, wr_d, a0_q, a0_d;
    logic [7:0]      dout_q, dout_d, data_q, data_d;
    logic [15:0]     fifo_mem [FIFO_DEPTH];

    logic            grant0, grant1, open, push, pop, launch;
    logic [15:0]     push_word, head;

    // rr_q = 1 means requester 1 is favoured on the next contended cycle
    assign grant0     = REQ0_VALID && (!REQ1_VALID || !rr_q);
    assign grant1     = REQ1_VALID && (!REQ0_VALID || rr_q);
    assign open       = run_q && (level_q < DEPTH_L) && !CLR;
    assign REQ0_READY = open && grant0;
    assign REQ1_READY = open && grant1;
    assign push       = REQ0_READY || REQ1_READY;
    assign push_word  = REQ0_READY ? {REQ0_REG, REQ0_DATA} : {REQ1_REG, REQ1_DATA};
    assign head       = fifo_mem[rd_ptr_q];

    assign OPLL_CS_n = cs_q;
    assign OPLL_WR_n = wr_q;
    assign OPLL_A0   = a0_q;
    assign OPLL_D    = dout_q;
    assign LEVEL     = level_q;
    assign BUSY      = (state_q != IDLE) || (level_q != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cs_d    = cs_q;
        wr_d    = wr_q;
        a0_d    = a0_q;
        dout_d  = dout_q;
        data_d  = data_q;
        launch  = 1'b0;
        case (state_q)
            IDLE: launch = (level_q != '0);
            ADR_WR: if (CLK_EN) begin
                if (cnt_q == '0) begin
                    state_d = ADR_WAIT;
                    cnt_d   = CW'(ADDR_WAIT - 1);
                    cs_d    = 1'b1;
                    wr_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ADR_WAIT: if (CLK_EN) begin
                if (cnt_q == '0) begin
                    state_d = DAT_WR;
                    cnt_d   = CW'(WR_TICKS - 1);
                    cs_d    = 1'b0;
                    wr_d    = 1'b0;
                    a0_d    = 1'b1;
                    dout_d  = data_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DAT_WR: if (CLK_EN) begin
                if (cnt_q == '0) begin
                    state_d = DAT_WAIT;
                    cnt_d   = CW'(DATA_WAIT - 1);
                    cs_d    = 1'b1;
                    wr_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DAT_WAIT: if (CLK_EN) begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    launch  = (level_q != '0);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Starting a write pops the head and drives the register address at once
        if (launch) begin
            state_d = ADR_WR;
            cnt_d   = CW'(WR_TICKS - 1);
            cs_d    = 1'b0;
            wr_d    = 1'b0;
            a0_d    = 1'b0;
            dout_d  = head[15:8];
            data_d  = head[7:0];
        end
        if (CLR) begin
            state_d = IDLE;
            cnt_d   = '0;
            cs_d    = 1'b1;
            wr_d    = 1'b1;
            a0_d    = 1'b0;
            dout_d  = '0;
            launch  = 1'b0;
        end
    end

    assign pop = launch;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        level_d  = level_q + LW'(push) - LW'(pop);
        rr_d     = push ? REQ0_READY : rr_q;
        if (CLR) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_word;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            level_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rr_q     <= 1'b0;
            run_q    <= 1'b0;
            cs_q     <= 1'b1;
            wr_q     <= 1'b1;
            a0_q     <= 1'b0;
            dout_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rr_q     <= rr_d;
            run_q    <= 1'b1;
            cs_q     <= cs_d;
            wr_q     <= wr_d;
            a0_q     <= a0_d;
            dout_q   <= dout_d;
            data_q   <= data_d;
        end
    end
endmodule

// File: tb/tb_opll_write_scheduler.sv
// Directed bench for opll_write_scheduler: timing, arbitration, FIFO full,
// CLK_EN pacing/freeze, CLR flush and asynchronous reset.
`define CHK(tag, obs, exp) \
    begin \
        n_cmp++; \
        assert ((obs) === (exp)) else begin \
            n_err++; \
            $error("FAIL %s: observed %0d expected %0d", tag, (obs), (exp)); \
        end \
    end

module tb_opll_write_scheduler;
    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       CLK_EN = 1'b0;
    logic       CLR = 1'b0;
    logic       REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
    logic       REQ0_READY, REQ1_READY;
    logic [7:0] REQ0_REG = 8'h00, REQ0_DATA = 8'h00;
    logic [7:0] REQ1_REG = 8'h00, REQ1_DATA = 8'h00;
    logic       OPLL_CS_n, OPLL_WR_n, OPLL_A0;
    logic [7:0] OPLL_D;
    logic       BUSY;
    logic [2:0] LEVEL;

    int n_cmp = 0;
    int n_err = 0;
    int en_mode = 0;
    int en_cnt = 0;

    opll_write_scheduler dut (
        .CLK(CLK), .RESET(RESET), .CLK_EN(CLK_EN), .CLR(CLR),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_REG(REQ0_REG), .REQ0_DATA(REQ0_DATA),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_REG(REQ1_REG), .REQ1_DATA(REQ1_DATA),
        .OPLL_CS_n(OPLL_CS_n), .OPLL_WR_n(OPLL_WR_n), .OPLL_A0(OPLL_A0), .OPLL_D(OPLL_D),
        .BUSY(BUSY), .LEVEL(LEVEL)
    );

    always #5 CLK = ~CLK;

    // mode 0: always enabled, 1: one tick in six, 2: held low with the phase frozen
    always @(negedge CLK) begin
        if (en_mode == 0) begin
            CLK_EN = 1'b1;
        end else if (en_mode == 1) begin
            CLK_EN = (en_cnt == 0);
            en_cnt = (en_cnt == 5) ? 0 : en_cnt + 1;
        end else begin
            CLK_EN = 1'b0;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_len(input logic v, output int n);
        n = 0;
        while (OPLL_CS_n === v && n < 6000) begin
            step();
            n++;
        end
    endtask

    int n, m, i0, i1, nacc, nw, nd, guard, lows, bad;
    int acc [6];
    logic [7:0] wreg [6];
    logic [7:0] wdat [6];
    logic [7:0] e;
    logic prev_cs;

    initial begin
        // Reset state, checked before any clock edge
        REQ0_VALID = 1'b1; REQ0_REG = 8'h10; REQ0_DATA = 8'h55;
        #1 RESET = 1'b1;
        #1;
        `CHK("rst_cs_n", OPLL_CS_n, 1'b1)
        `CHK("rst_wr_n", OPLL_WR_n, 1'b1)
        `CHK("rst_a0", OPLL_A0, 1'b0)
        `CHK("rst_d", OPLL_D, 8'h00)
        `CHK("rst_busy", BUSY, 1'b0)
        `CHK("rst_level", LEVEL, 3'd0)
        `CHK("rst_ready0", REQ0_READY, 1'b0)
        step(); step();
        RESET = 1'b0;
        #1;
        `CHK("rel_ready0_pre", REQ0_READY, 1'b0)
        step();
        `CHK("rel_level", LEVEL, 3'd0)
        `CHK("rel_ready0", REQ0_READY, 1'b1)
        $display("reset: compared=%0d", n_cmp);

        // Single write with CLK_EN always high
        step();
        REQ0_VALID = 1'b0;
        `CHK("single_level_acc", LEVEL, 3'd1)
        `CHK("single_cs_acc", OPLL_CS_n, 1'b1)
        step();
        `CHK("single_cs_low", OPLL_CS_n, 1'b0)
        `CHK("single_wr_low", OPLL_WR_n, 1'b0)
        `CHK("single_a0_adr", OPLL_A0, 1'b0)
        `CHK("single_d_adr", OPLL_D, 8'h10)
        `CHK("single_level_pop", LEVEL, 3'd0)
        run_len(1'b0, n);
        `CHK("single_adr_wr_len", n, 4)
        `CHK("single_a0_hold", OPLL_A0, 1'b0)
        `CHK("single_d_hold", OPLL_D, 8'h10)
        `CHK("single_wr_high", OPLL_WR_n, 1'b1)
        run_len(1'b1, n);
        `CHK("single_adr_wait_len", n, 72)
        `CHK("single_a0_dat", OPLL_A0, 1'b1)
        `CHK("single_d_dat", OPLL_D, 8'h55)
        run_len(1'b0, n);
        `CHK("single_dat_wr_len", n, 4)
        m = 0; lows = 0;
        while (BUSY && m < 2000) begin
            step();
            m++;
            if (!OPLL_CS_n) lows++;
        end
        `CHK("single_dat_wait_len", m, 504)
        `CHK("single_no_extra_cs", lows, 0)
        $display("single write: busy fell %0d cycles after first CS_n low", 80 + m);

        // Contention: fresh pointer, both requesters offering three writes
        RESET = 1'b1; step(); RESET = 1'b0; step();
        i0 = 0; i1 = 0; nacc = 0; nw = 0; nd = 0; guard = 0; prev_cs = 1'b1;
        while ((i0 < 3 || i1 < 3 || BUSY) && guard < 6000) begin
            REQ0_VALID = (i0 < 3); REQ0_REG = 8'hA0 + 8'(i0); REQ0_DATA = 8'h50 + 8'(i0);
            REQ1_VALID = (i1 < 3); REQ1_REG = 8'hB0 + 8'(i1); REQ1_DATA = 8'h60 + 8'(i1);
            #1;
            if (REQ0_VALID && REQ0_READY) begin
                if (nacc < 6) acc[nacc] = 0;
                nacc++; i0++;
            end else if (REQ1_VALID && REQ1_READY) begin
                if (nacc < 6) acc[nacc] = 1;
                nacc++; i1++;
            end
            step();
            if (prev_cs && !OPLL_CS_n) begin
                if (!OPLL_A0) begin
                    if (nw < 6) wreg[nw] = OPLL_D;
                    nw++;
                end else begin
                    if (nd < 6) wdat[nd] = OPLL_D;
                    nd++;
                end
            end
            prev_cs = OPLL_CS_n;
            guard++;
        end
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        `CHK("cont_accepts", nacc, 6)
        `CHK("cont_addr_writes", nw, 6)
        `CHK("cont_data_writes", nd, 6)
        for (int k = 0; k < 6; k++) begin
            if (k < nacc) `CHK("cont_accept_order", acc[k], k % 2)
            e = ((k % 2) == 0) ? 8'hA0 + 8'(k / 2) : 8'hB0 + 8'(k / 2);
            if (k < nw) `CHK("cont_write_reg", wreg[k], e)
            e = ((k % 2) == 0) ? 8'h50 + 8'(k / 2) : 8'h60 + 8'(k / 2);
            if (k < nd) `CHK("cont_write_data", wdat[k], e)
            $display("contention: slot %0d accepted from req%0d", k, acc[k]);
        end

        // Full FIFO: six back-to-back writes from requester 0
        REQ0_VALID = 1'b1;
        for (int k = 0; k < 5; k++) begin
            REQ0_REG = 8'hC0 + 8'(k); REQ0_DATA = 8'hD0 + 8'(k);
            #1;
            `CHK("full_ready_early", REQ0_READY, 1'b1)
            step();
        end
        REQ0_REG = 8'hC5; REQ0_DATA = 8'hD5;
        #1;
        `CHK("full_level4", LEVEL, 3'd4)
        `CHK("full_ready_low", REQ0_READY, 1'b0)
        n = 0;
        while (!REQ0_READY && n < 2000) begin
            step();
            n++;
        end
        `CHK("full_ready_wait", n, 581)
        `CHK("full_next_cs", OPLL_CS_n, 1'b0)
        `CHK("full_next_reg", OPLL_D, 8'hC1)
        `CHK("full_level3", LEVEL, 3'd3)
        step();
        REQ0_VALID = 1'b0;
        `CHK("full_sixth_acc", LEVEL, 3'd4)
        $display("full fifo: sixth write accepted after %0d cycles", n);
        CLR = 1'b1; step(); CLR = 1'b0;
        `CHK("full_flush_level", LEVEL, 3'd0)
        `CHK("full_flush_busy", BUSY, 1'b0)

        // CLR during DAT_WAIT with three entries queued
        REQ0_VALID = 1'b1;
        for (int k = 0; k < 4; k++) begin
            REQ0_REG = 8'h80 + 8'(k); REQ0_DATA = 8'h90 + 8'(k);
            step();
        end
        REQ0_VALID = 1'b0;
        `CHK("clr_level_fill", LEVEL, 3'd3)
        run_len(1'b0, n);
        run_len(1'b1, n);
        run_len(1'b0, n);
        repeat (10) step();
        `CHK("clr_pre_level", LEVEL, 3'd3)
        `CHK("clr_pre_cs", OPLL_CS_n, 1'b1)
        CLR = 1'b1; REQ0_VALID = 1'b1; REQ0_REG = 8'hEE;
        #1;
        `CHK("clr_ready0", REQ0_READY, 1'b0)
        step();
        CLR = 1'b0; REQ0_VALID = 1'b0;
        `CHK("clr_level", LEVEL, 3'd0)
        `CHK("clr_busy", BUSY, 1'b0)
        `CHK("clr_cs_n", OPLL_CS_n, 1'b1)
        `CHK("clr_wr_n", OPLL_WR_n, 1'b1)
        `CHK("clr_a0", OPLL_A0, 1'b0)
        `CHK("clr_d", OPLL_D, 8'h00)
        lows = 0;
        repeat (700) begin
            step();
            if (!OPLL_CS_n) lows++;
        end
        `CHK("clr_no_replay", lows, 0)
        $display("clr: flushed during DAT_WAIT");

        // CLK_EN one tick in six
        en_mode = 1;
        REQ0_VALID = 1'b1; REQ0_REG = 8'h33; REQ0_DATA = 8'h44;
        step();
        REQ0_VALID = 1'b0;
        step();
        `CHK("slow_cs_low", OPLL_CS_n, 1'b0)
        run_len(1'b0, n);
        run_len(1'b1, n);
        `CHK("slow_adr_wait_len", n, 432)
        `CHK("slow_d_dat", OPLL_D, 8'h44)
        run_len(1'b0, n);
        `CHK("slow_dat_wr_len", n, 24)
        m = 0;
        while (BUSY && m < 5000) begin
            step();
            m++;
        end
        `CHK("slow_dat_wait_len", m, 3024)
        $display("slow clk_en: data wait %0d cycles", m);

        // CLK_EN held low for 100 cycles inside ADR_WAIT
        REQ0_VALID = 1'b1; REQ0_REG = 8'h77; REQ0_DATA = 8'h88;
        step();
        REQ0_VALID = 1'b0;
        step();
        run_len(1'b0, n);
        n = 0;
        repeat (200) begin
            step();
            n++;
        end
        en_mode = 2;
        REQ0_VALID = 1'b1; REQ0_REG = 8'h99; REQ0_DATA = 8'hAA;
        #1;
        `CHK("freeze_ready0", REQ0_READY, 1'b1)
        step();
        n++;
        REQ0_VALID = 1'b0;
        bad = 0;
        repeat (99) begin
            step();
            n++;
            if (OPLL_CS_n !== 1'b1 || OPLL_A0 !== 1'b0 || OPLL_D !== 8'h77) bad++;
        end
        en_mode = 1;
        `CHK("freeze_outputs", bad, 0)
        `CHK("freeze_level", LEVEL, 3'd1)
        run_len(1'b1, m);
        `CHK("freeze_adr_wait_len", n + m, 532)
        CLR = 1'b1; step(); CLR = 1'b0;
        en_mode = 0;
        `CHK("freeze_flush_level", LEVEL, 3'd0)
        $display("freeze: adr wait %0d cycles", n + m);

        // Asynchronous reset in the middle of ADR_WR
        REQ0_VALID = 1'b1; REQ0_REG = 8'h21; REQ0_DATA = 8'h12;
        step();
        REQ0_VALID = 1'b0;
        step(); step();
        `CHK("arst_pre_cs", OPLL_CS_n, 1'b0)
        RESET = 1'b1;
        #1;
        `CHK("arst_cs_n", OPLL_CS_n, 1'b1)
        `CHK("arst_wr_n", OPLL_WR_n, 1'b1)
        `CHK("arst_busy", BUSY, 1'b0)
        `CHK("arst_level", LEVEL, 3'd0)
        REQ0_VALID = 1'b1; REQ0_REG = 8'h42; REQ0_DATA = 8'h24;
        #1;
        `CHK("arst_ready0", REQ0_READY, 1'b0)
        step();
        RESET = 1'b0;
        #1;
        `CHK("arst_rel_ready0", REQ0_READY, 1'b0)
        step();
        `CHK("arst_rel_level", LEVEL, 3'd0)
        `CHK("arst_rel_ready1", REQ0_READY, 1'b1)
        step();
        REQ0_VALID = 1'b0;
        `CHK("arst_acc_level", LEVEL, 3'd1)
        step();
        `CHK("arst_new_cs", OPLL_CS_n, 1'b0)
        `CHK("arst_new_a0", OPLL_A0, 1'b0)
        `CHK("arst_new_d", OPLL_D, 8'h42)
        run_len(1'b0, n);
        `CHK("arst_new_len", n, 4)
        $display("async reset: new write pulse %0d cycles", n);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
